// File: rtl/idt_cfg_pkg.sv
// Shared types and helpers for the IDT/ICS307 pixel-clock config loader.
package idt_cfg_pkg;

  localparam int unsigned R_BITS   = 7;
  localparam int unsigned V_BITS   = 9;
  localparam int unsigned S_BITS   = 3;
  localparam int unsigned F_BITS   = 2;
  localparam int unsigned C_BITS   = 2;
  localparam int unsigned CFG_BITS = C_BITS + 1 + F_BITS + S_BITS + V_BITS + R_BITS;

  typedef logic [CFG_BITS-1:0] cfg_word_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    STROBE,
    GAP
  } cfg_state_e;

  // Field order matches the synthesizer's shift order, MSB first.
  function automatic cfg_word_t pack_cfg(input logic [C_BITS-1:0] c,
                                         input logic              ttl,
                                         input logic [F_BITS-1:0] f,
                                         input logic [S_BITS-1:0] s,
                                         input logic [V_BITS-1:0] v,
                                         input logic [R_BITS-1:0] r);
    return {c, ttl, f, s, v, r};
  endfunction

endpackage

// File: rtl/idt_cfg_if.sv
// Config-word handshake between pixel-clock selection logic and the loader.
interface idt_cfg_if;
  import idt_cfg_pkg::*;

  logic      cfg_valid;
  logic      cfg_ready;
  cfg_word_t cfg_word;
  logic      busy;
  logic      done;

  modport master (
    output cfg_valid,
    output cfg_word,
    input  cfg_ready,
    input  busy,
    input  done
  );

  modport slave (
    input  cfg_valid,
    input  cfg_word,
    output cfg_ready,
    output busy,
    output done
  );
endinterface

// File: rtl/idt_cfg_tick.sv
// Loadable down-counter timing each loader state; expire flags the state's last cycle.
module idt_cfg_tick #(
  parameter int unsigned Width = 4
) (
  input  logic             osc_clk,
  input  logic             osc_reset,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             expire_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge osc_clk or posedge osc_reset) begin
    if (osc_reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire_o = (cnt_q == Width'(1));

endmodule

// File: rtl/idt_cfg_loader.sv
// Serial loader for the ICS307-style pixel-clock synthesizer: shifts a 24-bit word MSB-first.
// Build option IDT_CFG_AUTOLOAD_EN: shift DEFAULT_CFG automatically after every reset.
module idt_cfg_loader
  import idt_cfg_pkg::*;
#(
  parameter int unsigned SCLK_HALF   = 4,
  parameter cfg_word_t   DEFAULT_CFG = 24'h31149F
) (
  input  logic     osc_clk,
  input  logic     osc_reset,
  idt_cfg_if.slave cfg,
  output logic     idt_sclk,
  output logic     idt_data,
  output logic     idt_strobe
);

  localparam int unsigned      TickW   = $clog2(2 * SCLK_HALF + 1);
  localparam logic [TickW-1:0] TickH   = TickW'(SCLK_HALF);
  localparam logic [TickW-1:0] TickH2  = TickW'(2 * SCLK_HALF);
  localparam logic [4:0]       LastBit = 5'(CFG_BITS - 1);

  cfg_state_e       state_q;
  cfg_word_t        shreg_q;
  logic [4:0]       bit_cnt_q;
  logic             sclk_q, data_q, strobe_q, busy_q, done_q, ready_q;
  logic             auto_pend;
  logic             start;
  cfg_word_t        start_word;
  logic             tick_load;
  logic [TickW-1:0] tick_val;
  logic             expire;

`ifdef IDT_CFG_AUTOLOAD_EN
  localparam logic ReadyRst = 1'b0;
  logic auto_pend_q;

  always_ff @(posedge osc_clk or posedge osc_reset) begin
    if (osc_reset) begin
      auto_pend_q <= 1'b1;
    end else if (state_q == IDLE) begin
      auto_pend_q <= 1'b0;
    end
  end

  assign auto_pend = auto_pend_q;
`else
  localparam logic ReadyRst = 1'b1;
  assign auto_pend = 1'b0;
`endif

  always_comb begin
    start      = (state_q == IDLE) && (auto_pend || (cfg.cfg_valid && ready_q));
    start_word = auto_pend ? DEFAULT_CFG : cfg.cfg_word;
    tick_load  = start || ((state_q != IDLE) && expire);
    tick_val   = ((state_q == HIGH) && (bit_cnt_q == '0)) ? TickH2 : TickH;
  end

  idt_cfg_tick #(
    .Width (TickW)
  ) u_tick (
    .osc_clk    (osc_clk),
    .osc_reset  (osc_reset),
    .load_i     (tick_load),
    .load_val_i (tick_val),
    .expire_o   (expire)
  );

  always_ff @(posedge osc_clk or posedge osc_reset) begin
    if (osc_reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      sclk_q    <= 1'b0;
      data_q    <= 1'b0;
      strobe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= ReadyRst;
    end else begin
      // Pins are registered decodes of the state, so they trail it by one cycle.
      sclk_q   <= (state_q == HIGH);
      data_q   <= ((state_q == SETUP) || (state_q == HIGH)) && shreg_q[CFG_BITS-1];
      strobe_q <= (state_q == STROBE);
      busy_q   <= (state_q != IDLE);
      done_q   <= (state_q == IDLE) && busy_q;
      ready_q  <= (state_q == IDLE) && !start && !auto_pend;

      unique case (state_q)
        IDLE: begin
          if (start) begin
            shreg_q   <= start_word;
            bit_cnt_q <= LastBit;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          if (expire) state_q <= HIGH;
        end
        HIGH: begin
          if (expire) begin
            shreg_q   <= shreg_q << 1;
            bit_cnt_q <= bit_cnt_q - 1'b1;
            state_q   <= (bit_cnt_q == '0) ? STROBE : SETUP;
          end
        end
        STROBE: begin
          if (expire) state_q <= GAP;
        end
        GAP: begin
          if (expire) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign idt_sclk      = sclk_q;
  assign idt_data      = data_q;
  assign idt_strobe    = strobe_q;
  assign cfg.cfg_ready = ready_q;
  assign cfg.busy      = busy_q;
  assign cfg.done      = done_q;

endmodule

// File: tb/tb_idt_cfg_loader.sv
// Self-checking bench for idt_cfg_loader (H=4 and H=1 instances); honours IDT_CFG_AUTOLOAD_EN.
module tb_idt_cfg_loader;
  import idt_cfg_pkg::*;

  localparam int H4 = 4;
  localparam int H1 = 1;
`ifdef IDT_CFG_AUTOLOAD_EN
  localparam logic AutoLoad = 1'b1;
`else
  localparam logic AutoLoad = 1'b0;
`endif

  logic osc_clk;
  logic rst4, rst1;
  logic sclk4, data4, strb4;
  logic sclk1, data1, strb1;
  int   checks;
  int   failures;

  idt_cfg_if if4 ();
  idt_cfg_if if1 ();

  idt_cfg_loader #(.SCLK_HALF(H4), .DEFAULT_CFG(24'h31149F)) dut4 (
    .osc_clk    (osc_clk),
    .osc_reset  (rst4),
    .cfg        (if4),
    .idt_sclk   (sclk4),
    .idt_data   (data4),
    .idt_strobe (strb4)
  );

  idt_cfg_loader #(.SCLK_HALF(H1), .DEFAULT_CFG(24'h31149F)) dut1 (
    .osc_clk    (osc_clk),
    .osc_reset  (rst1),
    .cfg        (if1),
    .idt_sclk   (sclk1),
    .idt_data   (data1),
    .idt_strobe (strb1)
  );

  initial begin
    osc_clk = 1'b0;
    forever #5 osc_clk = ~osc_clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Timeline model: n cycles after the accept edge, phase = (n-1)/H; phases 0..47 are the
  // 24 low/high bit halves, 48..49 the strobe, 50 the gap, done lands on cycle 51H+1.
  function automatic logic [4:0] model_pins(input logic [23:0] w, input int h, input int n);
    int         ph;
    logic [4:0] r;
    ph   = (n - 1) / h;
    r[4] = (n >= 1) && (n <= 51 * h);
    r[3] = (ph < 48) && (ph % 2 == 1);
    r[2] = (ph < 48) ? w[23 - ph / 2] : 1'b0;
    r[1] = (ph == 48) || (ph == 49);
    r[0] = (n == 51 * h + 1);
    return r;
  endfunction

  task automatic accept4(input logic [23:0] w, input logic hold, output logic rdy);
    if4.cfg_valid = 1'b1;
    if4.cfg_word  = w;
    rdy = if4.cfg_ready;
    @(posedge osc_clk);
    #1;
    if (!hold) if4.cfg_valid = 1'b0;
  endtask

  task automatic watch4(input logic [23:0] exp_w, input int pulse_bit, input logic [23:0] w2,
                        output logic [23:0] bits, output int nbits, output int strb_len,
                        output int done_at, output int first_rise, output int ready_hi);
    logic prev, live, pulsed;
    prev = 1'b0; live = 1'b0; pulsed = 1'b0;
    bits = '0; nbits = 0; strb_len = 0; done_at = -1; first_rise = -1; ready_hi = 0;
    for (int n = 1; n <= 600; n++) begin
      @(posedge osc_clk);
      #1;
      if (live) begin
        if4.cfg_valid = 1'b0;
        live = 1'b0;
      end
      chk($sformatf("pins4 n=%0d", n), 32'({if4.busy, sclk4, data4, strb4, if4.done}),
          32'(model_pins(exp_w, H4, n)));
      if (sclk4 && !prev) begin
        if (first_rise < 0) first_rise = n;
        bits = {bits[22:0], data4};
        nbits++;
      end
      prev = sclk4;
      if (strb4) strb_len++;
      if (if4.cfg_ready && !if4.done) ready_hi++;
      if (if4.done) begin
        done_at = n;
        break;
      end
      if (!pulsed && pulse_bit > 0 && nbits == pulse_bit) begin
        if4.cfg_valid = 1'b1;
        if4.cfg_word  = w2;
        live   = 1'b1;
        pulsed = 1'b1;
      end
    end
  endtask

  task automatic run4(input logic [23:0] w, input int pulse_bit, input logic [23:0] w2,
                      input int exp_lat, input int exp_strb, input int exp_first);
    logic        rdy;
    logic [23:0] bits;
    int          nb, sl, da, fr, rh;
    accept4(w, 1'b0, rdy);
    chk("ready_at_accept", 32'(rdy), 32'd1);
    watch4(w, pulse_bit, w2, bits, nb, sl, da, fr, rh);
    chk("decoded_bits", 32'(bits), 32'(w));
    chk("sclk_rises", nb, 24);
    chk("strobe_len", sl, exp_strb);
    chk("done_latency", da, exp_lat);
    chk("first_rise", fr, exp_first);
    chk("ready_low_while_busy", rh, 0);
    chk("ready_at_done", 32'(if4.cfg_ready), 32'd1);
    if (pulse_bit > 0) begin
      repeat (4) begin
        @(posedge osc_clk);
        #1;
      end
      chk("no_second_load", 32'({if4.busy, sclk4}), 32'd0);
    end
  endtask

  task automatic after_reset4();
`ifdef IDT_CFG_AUTOLOAD_EN
    logic [23:0] bits;
    int          nb, sl, da, fr, rh;
    chk("auto_ready_low", 32'(if4.cfg_ready), 32'd0);
    @(posedge osc_clk);
    #1;
    watch4(24'h31149F, 0, 24'h0, bits, nb, sl, da, fr, rh);
    chk("auto_bits", 32'(bits), 32'h31149F);
    chk("auto_latency", da, 51 * H4 + 1);
    chk("auto_ready_low_busy", rh, 0);
    chk("auto_ready_at_done", 32'(if4.cfg_ready), 32'd1);
`else
    repeat (3) begin
      @(posedge osc_clk);
      #1;
    end
    chk("idle_after_reset", 32'({if4.cfg_ready, if4.busy, sclk4, data4, strb4}), 32'h10);
`endif
  endtask

  task automatic frame1(input logic [23:0] w);
    if1.cfg_valid = 1'b1;
    if1.cfg_word  = w;
    chk("h1_ready_at_accept", 32'(if1.cfg_ready), 32'd1);
    @(posedge osc_clk);
    #1;
    if1.cfg_valid = 1'b0;
    for (int n = 1; n <= 53; n++) begin
      @(posedge osc_clk);
      #1;
      chk($sformatf("pins1 n=%0d", n), 32'({if1.busy, sclk1, data1, strb1, if1.done}),
          32'(model_pins(w, H1, n)));
    end
  endtask

  typedef struct {
    logic [23:0] word;
    int          pulse_bit;
    logic [23:0] w2;
    int          exp_lat;
    int          exp_strb;
    int          exp_first;
  } vec_t;

  initial begin
    vec_t        tbl[$];
    logic        rdy;
    logic [23:0] bits;
    int          nb, sl, da, fr, rh, rises;
    logic        prev;
    logic        seen;

    checks = 0;
    failures = 0;
    rst4 = 1'b1;
    rst1 = 1'b1;
    if4.cfg_valid = 1'b0;
    if4.cfg_word  = '0;
    if1.cfg_valid = 1'b0;
    if1.cfg_word  = '0;
    repeat (3) @(posedge osc_clk);
    #1;
    chk("reset_pins", 32'({sclk4, data4, strb4, if4.busy, if4.done}), 32'd0);
    chk("reset_ready", 32'(if4.cfg_ready), 32'(!AutoLoad));
    rst4 = 1'b0;
    after_reset4();

    chk("pack_cfg", 32'(pack_cfg(2'b00, 1'b1, 2'b10, 3'b001, 9'd41, 7'd31)), 32'h31149F);

    tbl.push_back('{24'h31149F, 0, 24'h0, 51 * H4 + 1, 2 * H4, H4 + 1});
    tbl.push_back('{24'h800001, 0, 24'h0, 51 * H4 + 1, 2 * H4, H4 + 1});
    tbl.push_back('{24'h000000, 0, 24'h0, 51 * H4 + 1, 2 * H4, H4 + 1});
    tbl.push_back('{24'hC3C3C3, 10, 24'h3C3C3C, 51 * H4 + 1, 2 * H4, H4 + 1});
    for (int i = 0; i < 3; i++) begin
      tbl.push_back('{24'($urandom()), 0, 24'h0, 51 * H4 + 1, 2 * H4, H4 + 1});
    end
    foreach (tbl[i]) begin
      run4(tbl[i].word, tbl[i].pulse_bit, tbl[i].w2, tbl[i].exp_lat, tbl[i].exp_strb,
           tbl[i].exp_first);
    end

    // Back-to-back with cfg_valid held: second word must be taken on the done cycle.
    accept4(24'hA5A5A5, 1'b1, rdy);
    chk("b2b_ready_at_accept", 32'(rdy), 32'd1);
    if4.cfg_word = 24'h5A5A5A;
    watch4(24'hA5A5A5, 0, 24'h0, bits, nb, sl, da, fr, rh);
    chk("b2b_bits1", 32'(bits), 32'hA5A5A5);
    chk("b2b_latency1", da, 51 * H4 + 1);
    chk("b2b_strobe1", sl, 2 * H4);
    chk("b2b_ready_low_busy", rh, 0);
    chk("b2b_ready_at_done", 32'({if4.cfg_ready, sclk4}), 32'h2);
    @(posedge osc_clk);
    #1;
    if4.cfg_valid = 1'b0;
    watch4(24'h5A5A5A, 0, 24'h0, bits, nb, sl, da, fr, rh);
    chk("b2b_bits2", 32'(bits), 32'h5A5A5A);
    chk("b2b_rises2", nb, 24);
    chk("b2b_latency2", da, 51 * H4 + 1);
    chk("b2b_strobe2", sl, 2 * H4);

    // Reset in the middle of bit 12.
    accept4(24'h96C3E1, 1'b0, rdy);
    rises = 0;
    prev  = 1'b0;
    for (int n = 0; n < 400 && rises < 12; n++) begin
      @(posedge osc_clk);
      #1;
      if (sclk4 && !prev) rises++;
      prev = sclk4;
    end
    chk("rst_reached_bit12", rises, 12);
    #2;
    rst4 = 1'b1;
    #1;
    chk("rst_pins_low", 32'({sclk4, data4, strb4}), 32'd0);
    chk("rst_busy_done_low", 32'({if4.busy, if4.done}), 32'd0);
    chk("rst_ready", 32'(if4.cfg_ready), 32'(!AutoLoad));
    repeat (2) begin
      @(posedge osc_clk);
      #1;
      chk("rst_no_strobe_done", 32'({strb4, if4.done}), 32'd0);
    end
    rst4 = 1'b0;
    after_reset4();
    run4(24'h3C5A69, 0, 24'h0, 51 * H4 + 1, 2 * H4, H4 + 1);

    // H=1 instance: cycle-exact timeline against the model.
    rst1 = 1'b0;
`ifdef IDT_CFG_AUTOLOAD_EN
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(posedge osc_clk);
      #1;
      seen = if1.done;
    end
    chk("h1_autoload_done", 32'(seen), 32'd1);
`else
    @(posedge osc_clk);
    #1;
    seen = if1.busy;
    chk("h1_idle_after_reset", 32'(seen), 32'd0);
`endif
    frame1(24'hFFFFFF);
    frame1(24'($urandom()));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
